// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage piecewise-linear sigmoid/tanh unit on sign-magnitude fixed point.
// A runtime-programmable table covers the positive half; the negative half comes from symmetry.
module sigmoid_pwl_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 27,
    parameter int unsigned NSEG   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_sel,
    input  logic [$clog2(NSEG)-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]         cfg_wdata
);
    localparam int unsigned AW = $clog2(NSEG);
    localparam int unsigned MW = DATA_W - 1;
    localparam logic [MW-1:0] One = {{(MW - 1){1'b0}}, 1'b1} << FRAC_W;

    logic [MW-1:0] bp_q [NSEG];
    logic [MW-1:0] m_q  [NSEG];
    logic [MW-1:0] c_q  [NSEG];

    logic          cfg_addr_ok;
    logic          unused_cfg_sign;

    assign cfg_addr_ok     = {{(32 - AW){1'b0}}, cfg_addr} < NSEG;
    assign unused_cfg_sign = cfg_wdata[DATA_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NSEG); i++) begin
                bp_q[i] <= '0;
                m_q[i]  <= '0;
                c_q[i]  <= '0;
            end
        end else if (cfg_we && cfg_addr_ok) begin
            case (cfg_sel)
                2'd0:    bp_q[cfg_addr] <= cfg_wdata[MW-1:0];
                2'd1:    m_q[cfg_addr]  <= cfg_wdata[MW-1:0];
                2'd2:    c_q[cfg_addr]  <= cfg_wdata[MW-1:0];
                default: ;
            endcase
        end
    end

    // Stage registers
    logic          s1_valid_q, s1_neg_q, s1_tanh_q, s1_sat_q;
    logic [MW-1:0] s1_a_q, s1_m_q, s1_c_q;
    logic          s2_valid_q, s2_neg_q, s2_tanh_q, s2_sat_q;
    logic [MW-1:0] s2_p_q, s2_c_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    logic out_en, s2_en, s1_en;

    assign out_en    = ~out_valid_q | out_ready;
    assign s2_en     = ~s2_valid_q | out_en;
    assign s1_en     = ~s1_valid_q | s2_en;
    assign in_ready  = s1_en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // S1: magnitude, tanh doubling and priority segment lookup
    logic [MW-1:0] in_mag, s1_a_d, s1_m_d, s1_c_d;
    logic          in_neg, s1_sat_d;

    always_comb begin
        in_mag = in_data[MW-1:0];
        in_neg = in_data[DATA_W-1] && (in_mag != '0);
        if (!in_mode) begin
            s1_a_d = in_mag;
        end else if (in_mag[MW-1]) begin
            s1_a_d = '1;
        end else begin
            s1_a_d = {in_mag[MW-2:0], 1'b0};
        end
        s1_sat_d = 1'b1;
        s1_m_d   = '0;
        s1_c_d   = '0;
        // Walk downwards so the lowest matching index wins
        for (int i = int'(NSEG) - 1; i >= 0; i--) begin
            if (s1_a_d < bp_q[i]) begin
                s1_sat_d = 1'b0;
                s1_m_d   = m_q[i];
                s1_c_d   = c_q[i];
            end
        end
    end

    // S2: scaled product with saturation
    logic [2*MW-1:0] prod, prod_sh;
    logic [MW-1:0]   s2_p_d;

    always_comb begin
        prod    = {{MW{1'b0}}, s1_a_q} * {{MW{1'b0}}, s1_m_q};
        prod_sh = prod >> FRAC_W;
        s2_p_d  = (prod_sh[2*MW-1:MW] != '0) ? '1 : prod_sh[MW-1:0];
    end

    // S3: add intercept, clamp, then apply sigmoid or tanh symmetry
    logic [MW:0]       sum, two_f, tanh_diff;
    logic [MW-1:0]     f, y_mag;
    logic              y_sign;
    logic [DATA_W-1:0] out_data_d;

    always_comb begin
        sum       = {1'b0, s2_p_q} + {1'b0, s2_c_q};
        f         = (s2_sat_q || (sum > {1'b0, One})) ? One : sum[MW-1:0];
        two_f     = {f, 1'b0};
        tanh_diff = two_f - {1'b0, One};
        if (!s2_tanh_q) begin
            y_mag  = s2_neg_q ? (One - f) : f;
            y_sign = 1'b0;
        end else begin
            y_mag  = (two_f > {1'b0, One}) ? tanh_diff[MW-1:0] : '0;
            y_sign = s2_neg_q;
        end
        out_data_d = {y_sign && (y_mag != '0), y_mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_tanh_q   <= 1'b0;
            s1_sat_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_m_q      <= '0;
            s1_c_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_tanh_q   <= 1'b0;
            s2_sat_q    <= 1'b0;
            s2_p_q      <= '0;
            s2_c_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_neg_q  <= in_neg;
                    s1_tanh_q <= in_mode;
                    s1_sat_q  <= s1_sat_d;
                    s1_a_q    <= s1_a_d;
                    s1_m_q    <= s1_m_d;
                    s1_c_q    <= s1_c_d;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_neg_q  <= s1_neg_q;
                    s2_tanh_q <= s1_tanh_q;
                    s2_sat_q  <= s1_sat_q;
                    s2_p_q    <= s2_p_d;
                    s2_c_q    <= s1_c_q;
                end
            end
            if (out_en) begin
                out_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    out_data_q <= out_data_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Directed, table-driven bench for sigmoid_pwl_pipe with hand-computed expectations.
module tb_sigmoid_pwl_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] got[$];

    sigmoid_pwl_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) got.push_back(out_data);
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] x;
        logic        mode;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [2:0] addr, input logic [31:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Single sample with free-flowing output; checks accept, latency and value
    task automatic run_one(input logic [31:0] x, input logic mode, input logic [31:0] exp,
                           input string name);
        int cnt;
        in_valid = 1'b1; in_data = x; in_mode = mode;
        #1;
        check({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_latency"}, cnt, 32'd3);
        check({name, "_data"}, out_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[15];
        logic [31:0] bp_x[5];
        logic [31:0] bp_e[5];
        int acc;
        logic hs;

        vecs[0]  = '{32'h04000000, 1'b0, 32'h05000000};
        vecs[1]  = '{32'h84000000, 1'b0, 32'h03000000};
        vecs[2]  = '{32'h80000000, 1'b0, 32'h04000000};
        vecs[3]  = '{32'h02000000, 1'b1, 32'h02000000};
        vecs[4]  = '{32'h82000000, 1'b1, 32'h82000000};
        vecs[5]  = '{32'h00000000, 1'b1, 32'h00000000};
        vecs[6]  = '{32'h10000000, 1'b0, 32'h08000000};
        vecs[7]  = '{32'h90000000, 1'b0, 32'h00000000};
        vecs[8]  = '{32'h7FFFFFFF, 1'b1, 32'h08000000};
        vecs[9]  = '{32'h07FFFFFF, 1'b0, 32'h05FFFFFF};
        vecs[10] = '{32'h08000000, 1'b0, 32'h07000000};
        vecs[11] = '{32'h0E000000, 1'b0, 32'h08000000};
        vecs[12] = '{32'h84000000, 1'b1, 32'h86000000};
        vecs[13] = '{32'h88000000, 1'b0, 32'h01000000};
        vecs[14] = '{32'h80000000, 1'b1, 32'h00000000};

        bp_x = '{32'h04000000, 32'h84000000, 32'h10000000, 32'h90000000, 32'h00000000};
        bp_e = '{32'h05000000, 32'h03000000, 32'h08000000, 32'h00000000, 32'h04000000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cleared table saturates every sample
        run_one(32'h04000000, 1'b0, 32'h08000000, "empty_table");

        cfg_write(2'd0, 3'd0, 32'h08000000);
        cfg_write(2'd1, 3'd0, 32'h02000000);
        cfg_write(2'd2, 3'd0, 32'h04000000);
        cfg_write(2'd0, 3'd1, 32'h10000000);
        cfg_write(2'd1, 3'd1, 32'h02000000);
        cfg_write(2'd2, 3'd1, 32'h85000000);
        // Ignored writes: out-of-range address and sel=3
        cfg_write(2'd0, 3'd6, 32'h7FFFFFFF);
        cfg_write(2'd3, 3'd2, 32'h7FFFFFFF);

        for (int i = 0; i < 15; i++) begin
            run_one(vecs[i].x, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: only three samples fit
        out_ready = 1'b0;
        got.delete();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_data = bp_x[acc]; in_mode = 1'b0;
            #1;
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) acc++;
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted", acc, 32'd3);
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("bp_head_valid", {31'b0, out_valid}, 32'd1);
        check("bp_head_data", out_data, bp_e[0]);
        repeat (3) @(posedge clk);
        #1;
        check("bp_head_stable", out_data, bp_e[0]);
        check("bp_valid_stable", {31'b0, out_valid}, 32'd1);

        out_ready = 1'b1;
        for (int k = 0; k < 30 && got.size() < 5; k++) begin
            if (acc < 5) begin
                in_valid = 1'b1; in_data = bp_x[acc];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) acc++;
        end
        in_valid = 1'b0;
        check("bp_out_count", got.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_out%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, bp_e[i]);
        end
        repeat (4) @(posedge clk);
        #1;

        // Config race: intercept rewritten while samples are in flight
        got.delete();
        in_valid = 1'b1; in_data = 32'h04000000; in_mode = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_addr = 3'd0; cfg_wdata = 32'h02000000;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10 && got.size() < 3; k++) begin
            @(posedge clk); #1;
        end
        check("race_count", got.size(), 32'd3);
        check("race_out0", (got.size() > 0) ? got[0] : 32'hDEADBEEF, 32'h05000000);
        check("race_out1", (got.size() > 1) ? got[1] : 32'hDEADBEEF, 32'h05000000);
        check("race_out2", (got.size() > 2) ? got[2] : 32'hDEADBEEF, 32'h03000000);
        repeat (2) @(posedge clk);
        #1;

        // Reset with three samples in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h04000000; in_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("prerst_out_valid", {31'b0, out_valid}, 32'd1);
        got.delete();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("postrst_no_stale", got.size(), 32'd0);
        run_one(32'h04000000, 1'b0, 32'h08000000, "postrst_table_cleared");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
